fifo: RTL and testbench

//   Synchronous single-clock FIFO buffer of WIDTH-bit words, DEPTH entries deep.

---
 rtl/fifo_if.sv | 42 ++++
 rtl/fifo.sv | 86 ++++++++
 tb/tb_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_if.sv
// Push/pop handshake bundle between a producer/consumer and the fifo.
// FIFO_ERR_FLAGS_EN adds the sticky overflow_o / underflow_o flags.
interface fifo_if #(
    parameter int width = 16,
    parameter int depth = 8
);
    localparam int CW = $clog2(depth + 1);

    logic             push_i;
    logic             pop_i;
    logic [width-1:0] dato_i;
    logic [width-1:0] dato_o;
    logic             full_o;
    logic             empty_o;
    logic [CW-1:0]    count_o;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output push_i, pop_i, dato_i,
        input  dato_o, full_o, empty_o, count_o,
        input  overflow_o, underflow_o
    );

    modport slave (
        input  push_i, pop_i, dato_i,
        output dato_o, full_o, empty_o, count_o,
        output overflow_o, underflow_o
    );
`else
    modport master (
        output push_i, pop_i, dato_i,
        input  dato_o, full_o, empty_o, count_o
    );

    modport slave (
        input  push_i, pop_i, dato_i,
        output dato_o, full_o, empty_o, count_o
    );
`endif
endinterface

// File: rtl/fifo.sv
// Single-clock FIFO, any depth >= 2, registered pop data on dato_o.
// Optional sticky error flags via FIFO_ERR_FLAGS_EN.
module fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input logic   clk,
    input logic   rst,
    fifo_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [width-1:0] dout;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(depth));
    assign empty = (count == '0);

    // A pop is legal whenever data exists; a push on a full FIFO
    // only proceeds when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop  = bus.pop_i && !empty;
        do_push = bus.push_i && (!full || do_pop);
    end

    // Storage needs no reset; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= bus.dato_i;
    end

    // Pointers, occupancy and the registered read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == AW'(depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(depth - 1)) ? '0 : rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    // Sticky record of dropped pushes and ignored pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.push_i && !do_push)
                overflow <= 1'b1;
            if (bus.pop_i && !do_pop)
                underflow <= 1'b1;
        end
    end

    assign bus.overflow_o  = overflow;
    assign bus.underflow_o = underflow;
`endif

    assign bus.dato_o  = dout;
    assign bus.full_o  = full;
    assign bus.empty_o = empty;
    assign bus.count_o = count;
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: queue model compared every cycle,
// plus directed literal checks; a depth-5 instance exercises wrap.
module tb_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_if #(.width(16), .depth(8)) b8 ();
    fifo_if #(.width(16), .depth(5)) b5 ();

    fifo #(.width(16), .depth(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    fifo #(.width(16), .depth(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: a plain queue per instance.
    logic [15:0] q8[$];
    logic [15:0] q5[$];
    logic [15:0] m8_d;
    logic [15:0] m5_d;
    bit          m8_ov;
    bit          m8_un;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q8.delete();
            q5.delete();
            m8_d  = '0;
            m5_d  = '0;
            m8_ov = 0;
            m8_un = 0;
        end else begin
            bit p, u;
            p = b8.pop_i && q8.size() > 0;
            u = b8.push_i && (q8.size() < 8 || p);
            if (b8.pop_i && !p) m8_un = 1;
            if (b8.push_i && !u) m8_ov = 1;
            if (p) m8_d = q8.pop_front();
            if (u) q8.push_back(b8.dato_i);
            p = b5.pop_i && q5.size() > 0;
            u = b5.push_i && (q5.size() < 5 || p);
            if (p) m5_d = q5.pop_front();
            if (u) q5.push_back(b5.dato_i);
        end
    end

    // Compare DUT outputs to the model on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cnt8", int'(b8.count_o), q8.size());
            chk("emp8", int'(b8.empty_o), int'(q8.size() == 0));
            chk("full8", int'(b8.full_o), int'(q8.size() == 8));
            chk("dat8", int'(b8.dato_o), int'(m8_d));
            chk("cnt5", int'(b5.count_o), q5.size());
            chk("emp5", int'(b5.empty_o), int'(q5.size() == 0));
            chk("full5", int'(b5.full_o), int'(q5.size() == 5));
            chk("dat5", int'(b5.dato_o), int'(m5_d));
`ifdef FIFO_ERR_FLAGS_EN
            chk("ovf8", int'(b8.overflow_o), int'(m8_ov));
            chk("unf8", int'(b8.underflow_o), int'(m8_un));
`endif
        end
    end

    task automatic cyc(input bit pu, input bit po, input logic [15:0] d);
        b8.push_i = pu;
        b8.pop_i  = po;
        b8.dato_i = d;
        @(posedge clk);
        @(negedge clk);
        b8.push_i = 0;
        b8.pop_i  = 0;
    endtask

    task automatic cyc5(input bit pu, input bit po, input logic [15:0] d);
        b5.push_i = pu;
        b5.pop_i  = po;
        b5.dato_i = d;
        @(posedge clk);
        @(negedge clk);
        b5.push_i = 0;
        b5.pop_i  = 0;
    endtask

    initial begin
        b8.push_i = 0; b8.pop_i = 0; b8.dato_i = '0;
        b5.push_i = 0; b5.pop_i = 0; b5.dato_i = '0;

        // Reset state
        #1;
        chk("rst_dat", int'(b8.dato_o), 0);
        chk("rst_cnt", int'(b8.count_o), 0);
        chk("rst_emp", int'(b8.empty_o), 1);
        chk("rst_full", int'(b8.full_o), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf", int'(b8.overflow_o), 0);
        chk("rst_unf", int'(b8.underflow_o), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // Order and latency
        cyc(1, 0, 16'h6);
        cyc(1, 0, 16'hA);
        chk("ord_cnt", int'(b8.count_o), 2);
        chk("ord_emp", int'(b8.empty_o), 0);
        cyc(0, 1, '0);
        chk("ord_pop1", int'(b8.dato_o), 'h6);
        chk("ord_pop1_m", int'(m8_d), 'h6);
        cyc(0, 1, '0);
        chk("ord_pop2", int'(b8.dato_o), 'hA);
        chk("ord_emp2", int'(b8.empty_o), 1);

        // Pop on empty
        cyc(0, 1, '0);
        chk("emp_dat", int'(b8.dato_o), 'hA);
        chk("emp_cnt", int'(b8.count_o), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("emp_unf", int'(b8.underflow_o), 1);
`endif

        // Asynchronous reset mid-cycle
        cyc(1, 0, 16'h33);
        #2 rst = 1;
        #1;
        chk("arst_dat", int'(b8.dato_o), 0);
        chk("arst_cnt", int'(b8.count_o), 0);
        chk("arst_emp", int'(b8.empty_o), 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("arst_unf", int'(b8.underflow_o), 0);
`endif
        @(negedge clk);
        rst = 0;

        // Fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(i));
        chk("fill_full", int'(b8.full_o), 1);
        chk("fill_cnt", int'(b8.count_o), 8);
        cyc(1, 0, 16'h9);
        chk("ovf_cnt", int'(b8.count_o), 8);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_flag", int'(b8.overflow_o), 1);
`endif
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, '0);
            chk("drain", int'(b8.dato_o), i);
        end
        chk("drain_emp", int'(b8.empty_o), 1);

        // Simultaneous push/pop on full
        for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(8'h10 + i));
        cyc(1, 1, 16'h55);
        chk("sf_cnt", int'(b8.count_o), 8);
        chk("sf_dat", int'(b8.dato_o), 'h11);
        for (int i = 0; i < 8; i++) cyc(0, 1, '0);
        chk("sf_last", int'(b8.dato_o), 'h55);
        chk("sf_emp", int'(b8.empty_o), 1);

        // Simultaneous push/pop on empty
        cyc(1, 0, 16'h77);
        cyc(0, 1, '0);
        cyc(1, 1, 16'h55);
        chk("se_cnt", int'(b8.count_o), 1);
        chk("se_dat", int'(b8.dato_o), 'h77);
        cyc(0, 1, '0);
        chk("se_pop", int'(b8.dato_o), 'h55);

        // Interleaved traffic on depth 5 for pointer wrap
        for (int i = 0; i < 20; i++)
            cyc5(i % 3 != 2, i % 2 == 1, 16'(16'h100 + i));
        for (int i = 0; i < 6; i++) cyc5(0, 1, '0);
        chk("wrap_cnt", int'(b5.count_o), 0);
        chk("wrap_last", int'(b5.dato_o), 'h113);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
